// File: rtl/seg7_scan_driver.sv
// Multiplexed hex driver for NUM_DIGITS common-anode 7-segment digits on one shared segment bus.
// Optional build macro LEADING_ZERO_BLANK_EN turns off zero digits to the left of the first non-zero digit.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] DWELL_LAST_C = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST_C = CNT_W'(BLANK_LAST);
  localparam logic [IDX_W-1:0] IDX_LAST_C   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF      = 7'h7F;

  typedef enum logic {
    ST_BLANK,
    ST_SCAN
  } state_e;

  state_e                  stateQ, stateD;
  logic [CNT_W-1:0]        cntQ, cntD;
  logic [IDX_W-1:0]        idxQ, idxD;
  logic [4*NUM_DIGITS-1:0] dataShQ;
  logic [NUM_DIGITS-1:0]   dpShQ;
  logic [6:0]              segQ, segD;
  logic                    dpQ, dpD;
  logic [NUM_DIGITS-1:0]   anQ, anD;
  logic                    frameQ, frameD;

  logic [IDX_W-1:0]        idxWrap;
  logic [IDX_W-1:0]        enterIdx;
  logic [3:0]              enterNibble;
  logic                    blankDigit;

  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // A slot entered from BLANK lights the current index; a back-to-back slot lights the next one.
  assign idxWrap     = (idxQ == IDX_LAST_C) ? '0 : idxQ + IDX_W'(1);
  assign enterIdx    = (stateQ == ST_SCAN) ? idxWrap : idxQ;
  assign enterNibble = dataShQ[{enterIdx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] leadZero;
  logic                  runZero;

  always_comb begin
    leadZero = '0;
    runZero  = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
      runZero     = runZero && (dataShQ[4*j +: 4] == 4'h0);
      leadZero[j] = runZero;
    end
  end

  assign blankDigit = leadZero[enterIdx];
`else
  assign blankDigit = 1'b0;
`endif

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ + CNT_W'(1);
    idxD   = idxQ;
    segD   = segQ;
    dpD    = dpQ;
    anD    = anQ;
    frameD = 1'b0;

    case (stateQ)
      ST_BLANK: begin
        if ((BLANK_CYCLES == 0) || (cntQ == BLANK_LAST_C)) begin
          stateD = ST_SCAN;
          cntD   = '0;
        end
      end
      ST_SCAN: begin
        if (cntQ == DWELL_LAST_C) begin
          idxD = idxWrap;
          cntD = '0;
          if (BLANK_CYCLES != 0) begin
            stateD = ST_BLANK;
            segD   = SEG_OFF;
            dpD    = 1'b1;
            anD    = '1;
          end
        end
      end
      default: begin
        stateD = ST_BLANK;
        cntD   = '0;
      end
    endcase

    // Everything a lit slot shows is latched here, once, so mid-slot loads cannot disturb it.
    if ((stateD == ST_SCAN) && (cntD == '0)) begin
      segD   = blankDigit ? SEG_OFF : decodeHex(enterNibble);
      dpD    = ~dpShQ[enterIdx];
      anD    = '1;
      if (digit_en[enterIdx]) begin
        anD[enterIdx] = 1'b0;
      end
      frameD = (enterIdx == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_BLANK;
      cntQ   <= '0;
      idxQ   <= '0;
      segQ   <= SEG_OFF;
      dpQ    <= 1'b1;
      anQ    <= '1;
      frameQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      idxQ   <= idxD;
      segQ   <= segD;
      dpQ    <= dpD;
      anQ    <= anD;
      frameQ <= frameD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataShQ <= '0;
      dpShQ   <= '0;
    end else if (load) begin
      dataShQ <= data_in;
      dpShQ   <= dp_in;
    end
  end

  assign seg_out     = segQ;
  assign dp_out      = dpQ;
  assign an_out      = anQ;
  assign frame_start = frameQ;

endmodule
